// File: rtl/cpu7_exu_eclpipe_pkg.sv
// Shared types for the cpu7 E/M/W register-tag pipeline: index width,
// load-wait FSM encoding and the per-stage tag records.
package cpu7_exu_eclpipe_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef enum logic {
        M_RUN    = 1'b0,
        M_LDWAIT = 1'b1
    } ldw_state_e;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     wen;
        logic     load;
        reg_idx_t rs1;
        reg_idx_t rs2;
        logic     use1;
        logic     use2;
    } e_tag_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     wen;
        logic     load;
    } m_tag_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     wen;
    } w_tag_t;

endpackage

// File: rtl/cpu7_exu_eclhzd.sv
// Load-use comparator: flags an E-stage operand that needs the result of the
// load currently in M, which is not bypassable until it reaches W.
module cpu7_exu_eclhzd (
    input  logic       e_valid_i,
    input  logic [4:0] e_rs1_i,
    input  logic [4:0] e_rs2_i,
    input  logic       e_use1_i,
    input  logic       e_use2_i,
    input  logic       m_valid_i,
    input  logic [4:0] m_rd_i,
    input  logic       m_wen_i,
    input  logic       m_load_i,
    output logic       hz_o
);

    logic m_load_wr;
    logic src_match;

    // r0 is hardwired zero, so a load targeting it can never feed a consumer.
    assign m_load_wr = m_valid_i & m_load_i & m_wen_i & (m_rd_i != 5'd0);
    assign src_match = (e_use1_i & (e_rs1_i == m_rd_i))
                     | (e_use2_i & (e_rs2_i == m_rd_i));
    assign hz_o      = e_valid_i & m_load_wr & src_match;

endmodule

// File: rtl/cpu7_exu_eclpipe.sv
// Register-tag pipeline for the cpu7 execute unit: carries destination and
// source tags through E/M/W and generates load-use / load-wait stalls.
module cpu7_exu_eclpipe
    import cpu7_exu_eclpipe_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       d_valid,
    input  logic [4:0] d_rd,
    input  logic       d_wen,
    input  logic       d_load,
    input  logic [4:0] d_rs1,
    input  logic [4:0] d_rs2,
    input  logic       d_rs1_use,
    input  logic       d_rs2_use,
    input  logic       e_busy,
    input  logic       flush_e,
    input  logic       lsu_data_vld,
    output logic [4:0] rs1_e,
    output logic [4:0] rs2_e,
    output logic [4:0] rd_m,
    output logic       wen_m,
    output logic [4:0] rd_w,
    output logic       wen_w,
    output logic       e_valid_o,
    output logic       stall_d
);

    e_tag_t     e_q, e_d;
    m_tag_t     m_q, m_d;
    w_tag_t     w_q, w_d;
    ldw_state_e state_q, state_d;

    logic ld_wait;
    logic hz;
    logic e_hold;

    cpu7_exu_eclhzd u_hzd (
        .e_valid_i (e_q.valid),
        .e_rs1_i   (e_q.rs1),
        .e_rs2_i   (e_q.rs2),
        .e_use1_i  (e_q.use1),
        .e_use2_i  (e_q.use2),
        .m_valid_i (m_q.valid),
        .m_rd_i    (m_q.rd),
        .m_wen_i   (m_q.wen),
        .m_load_i  (m_q.load),
        .hz_o      (hz)
    );

    assign e_hold  = e_busy | ld_wait | hz;
    assign stall_d = e_hold & ~flush_e;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= M_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            M_RUN:    if (m_q.valid && m_q.load && !lsu_data_vld) state_d = M_LDWAIT;
            M_LDWAIT: if (lsu_data_vld) state_d = M_RUN;
            default:  state_d = M_RUN;
        endcase
    end

    // In M_LDWAIT the load is known to be parked in M, so only the return matters.
    always_comb begin
        ld_wait = 1'b0;
        case (state_q)
            M_RUN:    ld_wait = m_q.valid & m_q.load & ~lsu_data_vld;
            M_LDWAIT: ld_wait = ~lsu_data_vld;
            default:  ld_wait = 1'b0;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_d = w_q;
        m_d = m_q;
        e_d = e_q;

        if (ld_wait) begin
            w_d = '0;
        end else begin
            w_d = '{valid: m_q.valid, rd: m_q.rd, wen: m_q.wen};
        end

        // A flushed E instruction is killed, so it leaves a bubble rather than advancing.
        if (!ld_wait) begin
            if (e_hold || flush_e) begin
                m_d = '0;
            end else begin
                m_d = '{valid: e_q.valid, rd: e_q.rd, wen: e_q.wen, load: e_q.load};
            end
        end

        if (flush_e) begin
            e_d = '0;
        end else if (!e_hold) begin
            e_d = '{valid: d_valid, rd: d_rd, wen: d_wen, load: d_load,
                    rs1: d_rs1, rs2: d_rs2, use1: d_rs1_use, use2: d_rs2_use};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

    assign rs1_e     = e_q.rs1;
    assign rs2_e     = e_q.rs2;
    assign e_valid_o = e_q.valid;
    assign rd_m      = m_q.rd;
    assign wen_m     = m_q.valid & m_q.wen & ~m_q.load;
    assign rd_w      = w_q.rd;
    assign wen_w     = w_q.valid & w_q.wen;

endmodule

// File: tb/tb_cpu7_exu_eclpipe.sv
// Self-checking bench for cpu7_exu_eclpipe: directed scenarios followed by a
// random stream, all compared against a stage-by-stage instruction model.
module tb_cpu7_exu_eclpipe;
    import cpu7_exu_eclpipe_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       d_valid, d_wen, d_load, d_rs1_use, d_rs2_use;
    logic [4:0] d_rd, d_rs1, d_rs2;
    logic       e_busy, flush_e, lsu_data_vld;
    logic [4:0] rs1_e, rs2_e, rd_m, rd_w;
    logic       wen_m, wen_w, e_valid_o, stall_d;

    always #5 clk = ~clk;

    cpu7_exu_eclpipe dut (
        .clk          (clk),
        .reset        (reset),
        .d_valid      (d_valid),
        .d_rd         (d_rd),
        .d_wen        (d_wen),
        .d_load       (d_load),
        .d_rs1        (d_rs1),
        .d_rs2        (d_rs2),
        .d_rs1_use    (d_rs1_use),
        .d_rs2_use    (d_rs2_use),
        .e_busy       (e_busy),
        .flush_e      (flush_e),
        .lsu_data_vld (lsu_data_vld),
        .rs1_e        (rs1_e),
        .rs2_e        (rs2_e),
        .rd_m         (rd_m),
        .wen_m        (wen_m),
        .rd_w         (rd_w),
        .wen_w        (wen_w),
        .e_valid_o    (e_valid_o),
        .stall_d      (stall_d)
    );

    // One in-flight instruction as the model sees it; an empty slot is all zero.
    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       wen;
        bit       ld;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit       u1;
        bit       u2;
    } instr_t;

    instr_t ex, mm, wb;
    bit     waiting;
    int     tests  = 0;
    int     failed = 0;
    int     stall_cnt, ldw_cnt, rd10_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic dv, input logic [4:0] rd, input logic wen,
                        input logic ld, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic busy, input logic fl,
                        input logic lsu);
        instr_t empty, dins;
        bit     ldw, hz, hold;
        empty = '{default: 0};
        dins  = '{v: dv, rd: rd, wen: wen, ld: ld, rs1: rs1, rs2: rs2, u1: u1, u2: u2};

        @(negedge clk);
        reset = rst; d_valid = dv; d_rd = rd; d_wen = wen; d_load = ld;
        d_rs1 = rs1; d_rs2 = rs2; d_rs1_use = u1; d_rs2_use = u2;
        e_busy = busy; flush_e = fl; lsu_data_vld = lsu;
        #1;

        ldw  = mm.v && mm.ld && !lsu;
        hz   = ex.v && mm.v && mm.ld && mm.wen && (mm.rd != 0)
            && ((ex.u1 && ex.rs1 == mm.rd) || (ex.u2 && ex.rs2 == mm.rd));
        hold = busy || ldw || hz;

        check("stall_d", 32'(stall_d), 32'(hold && !fl));
        check("e_valid_o", 32'(e_valid_o), 32'(ex.v));
        if (ex.v) begin
            check("rs1_e", 32'(rs1_e), 32'(ex.rs1));
            check("rs2_e", 32'(rs2_e), 32'(ex.rs2));
        end
        check("wen_m", 32'(wen_m), 32'(mm.v && mm.wen && !mm.ld));
        if (mm.v) check("rd_m", 32'(rd_m), 32'(mm.rd));
        check("wen_w", 32'(wen_w), 32'(wb.v && wb.wen));
        if (wb.v) check("rd_w", 32'(rd_w), 32'(wb.rd));
        check("fsm", 32'(dut.state_q), 32'(waiting ? M_LDWAIT : M_RUN));

        if (stall_d === 1'b1) stall_cnt++;
        if (dut.state_q === M_LDWAIT) ldw_cnt++;
        if (mm.v || rd_m === 5'd10) if (rd_m === 5'd10) rd10_seen++;

        if (rst) begin
            ex = empty; mm = empty; wb = empty; waiting = 0;
        end else begin
            wb      = ldw ? empty : mm;
            mm      = ldw ? mm : ((hold || fl) ? empty : ex);
            ex      = fl ? empty : (hold ? ex : dins);
            waiting = ldw;
        end
    endtask

    task automatic nop(input logic lsu);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, lsu);
    endtask

    initial begin
        reset = 1'b1; d_valid = 0; d_rd = 0; d_wen = 0; d_load = 0;
        d_rs1 = 0; d_rs2 = 0; d_rs1_use = 0; d_rs2_use = 0;
        e_busy = 0; flush_e = 0; lsu_data_vld = 0;
        ex = '{default: 0}; mm = '{default: 0}; wb = '{default: 0}; waiting = 0;
        repeat (2) @(posedge clk);
        nop(0);

        // Straight-line ALU stream: tags appear in M two cycles after accept.
        stall_cnt = 0;
        step(0, 1, 1, 1, 0, 4, 6, 1, 1, 0, 0, 0);
        step(0, 1, 2, 1, 0, 7, 8, 1, 0, 0, 0, 0);
        step(0, 1, 3, 1, 0, 9, 1, 0, 1, 0, 0, 0);
        repeat (4) nop(0);
        check("alu_no_stall", 32'(stall_cnt), 32'd0);

        // Load r5 then consumer of r5, data returns in the load's first M cycle.
        stall_cnt = 0;
        step(0, 1, 5, 1, 1, 2, 0, 1, 0, 0, 0, 0);
        step(0, 1, 6, 1, 0, 5, 3, 1, 1, 0, 0, 0);
        nop(1);
        repeat (4) nop(0);
        check("load_use_one_bubble", 32'(stall_cnt), 32'd1);

        // Load return withheld for three cycles.
        stall_cnt = 0; ldw_cnt = 0;
        step(0, 1, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        nop(0);
        repeat (3) nop(0);
        nop(1);
        repeat (3) nop(0);
        check("ldwait_cycles", 32'(ldw_cnt), 32'd3);
        check("ldwait_stalls", 32'(stall_cnt), 32'd3);

        // r0 load feeding an r0 consumer never stalls.
        stall_cnt = 0;
        step(0, 1, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0);
        step(0, 1, 4, 1, 0, 0, 0, 1, 1, 0, 0, 0);
        nop(1);
        repeat (3) nop(0);
        check("r0_no_stall", 32'(stall_cnt), 32'd0);

        // Flush while E is busy and decode offers rd=10.
        rd10_seen = 0;
        step(0, 1, 9, 1, 0, 1, 2, 1, 1, 0, 0, 0);
        step(0, 1, 10, 1, 0, 1, 2, 1, 1, 1, 1, 0);
        repeat (4) nop(0);
        check("flush_drops_d", 32'(rd10_seen), 32'd0);

        // Reset while a load is waiting, then a stale return.
        step(0, 1, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        nop(0);
        nop(0);
        nop(0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop(1);
        repeat (3) nop(0);

        // Random stream over a small register range so hazards are frequent.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(199) == 0), ($urandom_range(3) != 0),
                 5'($urandom_range(3)), 1'($urandom), ($urandom_range(2) == 0),
                 5'($urandom_range(3)), 5'($urandom_range(3)), 1'($urandom), 1'($urandom),
                 ($urandom_range(7) == 0), ($urandom_range(15) == 0), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
